// File: rtl/mapper_ss_sequencer.sv
// mapper_ss_sequencer
// ---------------------------------------------------------------------------
// Savestate sequencer placed directly upstream of the mapper savestate
// registers. It drives the shared SaveStateBus and a word-addressed savestate
// memory.
//
//   Save : for each index idx in [SS_FIRST, SS_FIRST+SS_COUNT-1], present idx
//          on SaveStateBus_Adr, capture SaveStateBus_Dout and write it to
//          memory word (idx - SS_FIRST).
//   Load : pulse SaveStateBus_rst, then for each index read memory word
//          (idx - SS_FIRST), write it onto the bus with SaveStateBus_wren, and
//          finally hold SaveStateBus_load for LOAD_CYCLES cycles.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   start_save, start_load  single-cycle requests (save wins if both)
//   busy, done              sequence in progress / one-cycle completion pulse
//   mem_req/we/addr/wdata   memory request, held until mem_ack
//   mem_rdata, mem_ack      memory read data and one-cycle acknowledge
//   SaveStateBus_Din/Adr/wren/rst/load  shared bus towards the mappers
//   SaveStateBus_Dout       ORed read data from the mappers (combinational on Adr)
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module mapper_ss_sequencer #(
    parameter logic [9:0] SS_FIRST    = 10'd32,
    parameter int         SS_COUNT    = 32'd16,
    parameter int         LOAD_CYCLES = 32'd2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_save,
    input  logic        start_load,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic [63:0] SaveStateBus_Din,
    output logic [9:0]  SaveStateBus_Adr,
    output logic        SaveStateBus_wren,
    output logic        SaveStateBus_rst,
    output logic        SaveStateBus_load,
    input  logic [63:0] SaveStateBus_Dout
);

    // Last index walked; the range never wraps past 1023.
    localparam logic [9:0] SS_LAST   = SS_FIRST + 10'(SS_COUNT - 32'd1);
    localparam logic [3:0] LOAD_INIT = 4'(LOAD_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        S_ADR   = 3'd1,
        S_MEM   = 3'd2,
        L_RST   = 3'd3,
        L_MEM   = 3'd4,
        L_WR    = 3'd5,
        L_APPLY = 3'd6,
        FIN     = 3'd7
    } state_t;

    state_t      state_r;
    logic [9:0]  idx_r;
    logic [3:0]  cnt_r;
    logic        busy_r;
    logic        done_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [9:0]  mem_addr_r;
    logic [63:0] mem_wdata_r;
    logic [63:0] din_r;
    logic [9:0]  adr_r;
    logic        wren_r;
    logic        rst_r;
    logic        load_r;

    // Sequencer FSM; every output is produced by this single registered block.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            idx_r       <= SS_FIRST;
            cnt_r       <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 10'd0;
            mem_wdata_r <= 64'd0;
            din_r       <= 64'd0;
            adr_r       <= SS_FIRST;
            wren_r      <= 1'b0;
            rst_r       <= 1'b0;
            load_r      <= 1'b0;
        end else begin
            // Single-cycle strobes fall back to 0 unless a state re-asserts them.
            done_r <= 1'b0;
            wren_r <= 1'b0;
            rst_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_save) begin
                        // Save has priority; a simultaneous start_load is dropped.
                        state_r <= S_ADR;
                        idx_r   <= SS_FIRST;
                        adr_r   <= SS_FIRST;
                        busy_r  <= 1'b1;
                    end else if (start_load) begin
                        state_r <= L_RST;
                        rst_r   <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                S_ADR: begin
                    // Adr has been stable for a full cycle, so Dout is settled.
                    mem_wdata_r <= SaveStateBus_Dout;
                    mem_req_r   <= 1'b1;
                    mem_we_r    <= 1'b1;
                    mem_addr_r  <= idx_r - SS_FIRST;
                    state_r     <= S_MEM;
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req_r <= 1'b0;
                        if (idx_r == SS_LAST) begin
                            state_r <= FIN;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            idx_r   <= idx_r + 10'd1;
                            adr_r   <= idx_r + 10'd1;
                            state_r <= S_ADR;
                        end
                    end else begin
                        state_r <= S_MEM;
                    end
                end
                L_RST: begin
                    idx_r      <= SS_FIRST;
                    mem_req_r  <= 1'b1;
                    mem_we_r   <= 1'b0;
                    mem_addr_r <= 10'd0;
                    state_r    <= L_MEM;
                end
                L_MEM: begin
                    if (mem_ack) begin
                        mem_req_r <= 1'b0;
                        din_r     <= mem_rdata;
                        adr_r     <= idx_r;
                        wren_r    <= 1'b1;
                        state_r   <= L_WR;
                    end else begin
                        state_r <= L_MEM;
                    end
                end
                L_WR: begin
                    if (idx_r == SS_LAST) begin
                        load_r  <= 1'b1;
                        cnt_r   <= LOAD_INIT;
                        state_r <= L_APPLY;
                    end else begin
                        idx_r      <= idx_r + 10'd1;
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= idx_r + 10'd1 - SS_FIRST;
                        state_r    <= L_MEM;
                    end
                end
                L_APPLY: begin
                    // load was raised on entry, so it stays high for LOAD_INIT cycles.
                    if (cnt_r == 4'd1) begin
                        load_r  <= 1'b0;
                        cnt_r   <= 4'd0;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= FIN;
                    end else begin
                        cnt_r   <= cnt_r - 4'd1;
                        state_r <= L_APPLY;
                    end
                end
                FIN: begin
                    // Starts arriving while done is high are ignored.
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    mem_req_r <= 1'b0;
                    load_r    <= 1'b0;
                end
            endcase
        end
    end

    assign busy              = busy_r;
    assign done              = done_r;
    assign mem_req           = mem_req_r;
    assign mem_we            = mem_we_r;
    assign mem_addr          = mem_addr_r;
    assign mem_wdata         = mem_wdata_r;
    assign SaveStateBus_Din  = din_r;
    assign SaveStateBus_Adr  = adr_r;
    assign SaveStateBus_wren = wren_r;
    assign SaveStateBus_rst  = rst_r;
    assign SaveStateBus_load = load_r;

endmodule
